// File: rtl/alu_share_arbiter_if.sv
// Bundle of the requester, ALU-drive and response signals of the shared-ALU arbiter.
// master: the surrounding environment (requesters, ALU, response consumer).
// slave : the arbiter itself.
interface alu_share_arbiter_if #(
    parameter int WIDTH  = 16,
    parameter int CTRL_W = 3
);
    logic              req_valid0;
    logic              req_valid1;
    logic              req_ready0;
    logic              req_ready1;
    logic [WIDTH-1:0]  req_a0;
    logic [WIDTH-1:0]  req_b0;
    logic [WIDTH-1:0]  req_a1;
    logic [WIDTH-1:0]  req_b1;
    logic [CTRL_W-1:0] req_op0;
    logic [CTRL_W-1:0] req_op1;
    logic [WIDTH-1:0]  alu_a;
    logic [WIDTH-1:0]  alu_b;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [WIDTH-1:0]  alu_result;
    logic              alu_zero;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [WIDTH-1:0]  rsp_result;
    logic              rsp_zero;
    logic              busy;

    modport master (
        output req_valid0, req_valid1, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1,
        input  req_ready0, req_ready1,
        input  alu_a, alu_b, alu_ctrl,
        output alu_result, alu_zero,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, busy,
        output rsp_ready
    );

    modport slave (
        input  req_valid0, req_valid1, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1,
        output req_ready0, req_ready1,
        output alu_a, alu_b, alu_ctrl,
        input  alu_result, alu_zero,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, busy,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the execute stage (port 0)
// and the address/branch-compare unit (port 1). One operation in flight at a time:
// accept -> drive ALU for one cycle -> hold tagged response until the consumer takes it.
module alu_share_arbiter #(
    parameter int WIDTH  = 16,
    parameter int CTRL_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_share_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_prio;
    logic [WIDTH-1:0]  r_alu_a;
    logic [WIDTH-1:0]  r_alu_b;
    logic [CTRL_W-1:0] r_alu_ctrl;
    logic              r_rsp_id;
    logic [WIDTH-1:0]  r_rsp_result;
    logic              r_rsp_zero;

    logic              w_grant0;
    logic              w_grant1;
    logic              w_ready0;
    logic              w_ready1;
    logic              w_accept;

    // State register; reset abandons any in-flight operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: accept in IDLE, one ALU cycle in EXEC, wait for consumer in RESP.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_EXEC;
            S_EXEC:  w_next = S_RESP;
            S_RESP:  if (bus.rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Grant/ready: a lone requester always wins, contention resolved by r_prio.
    // Depends only on valids, state and prio (never on rsp_ready).
    always_comb begin
        w_grant0 = bus.req_valid0 & (~bus.req_valid1 | ~r_prio);
        w_grant1 = bus.req_valid1 & (~bus.req_valid0 |  r_prio);
        w_ready0 = (r_state == S_IDLE) & rst_n & w_grant0;
        w_ready1 = (r_state == S_IDLE) & rst_n & w_grant1;
        w_accept = w_ready0 | w_ready1;
    end

    // Operand capture at accept, result capture at end of EXEC; prio flips to the loser.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prio       <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_ctrl   <= '0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_a    <= w_ready1 ? bus.req_a1  : bus.req_a0;
                r_alu_b    <= w_ready1 ? bus.req_b1  : bus.req_b0;
                r_alu_ctrl <= w_ready1 ? bus.req_op1 : bus.req_op0;
                r_rsp_id   <= w_ready1;
                r_prio     <= w_ready0;
            end
            if (r_state == S_EXEC) begin
                r_rsp_result <= bus.alu_result;
                r_rsp_zero   <= bus.alu_zero;
            end
        end
    end

    assign bus.req_ready0 = w_ready0;
    assign bus.req_ready1 = w_ready1;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_ctrl   = r_alu_ctrl;
    assign bus.rsp_valid  = (r_state == S_RESP);
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_zero   = r_rsp_zero;
    assign bus.busy       = (r_state != S_IDLE);
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares the single combinational 16-bit ALU between two requesters: port 0 is the datapath execute stage and port 1 is the address/branch-compare unit. The block arbitrates round-robin, registers the winner's operands and opcode onto the ALU inputs, and captures `Result`/`Zero`. It returns them on one tagged response channel with valid/ready backpressure. One operation is in flight at a time.

## Interface
- `WIDTH`, 16, operand and result width; must match the ALU.
- `CTRL_W`, 3, ALU_Control width. Opcodes: 0 add, 1 sub, 5 and, 7 slt. Other codes are forwarded unchanged and not checked.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous reset, active-low; sampled on the rising edge of `clk`.
- `req_valid0`, `req_valid1`  in  1  requester has an operation pending.
- `req_ready0`, `req_ready1`  out  1  operation accepted this cycle when paired with valid.
- `req_a0`, `req_b0`, `req_a1`, `req_b1`  in  WIDTH  operands.
- `req_op0`, `req_op1`  in  CTRL_W  ALU opcode.
- `alu_a`, `alu_b`  out  WIDTH  registered ALU operand drive.
- `alu_ctrl`  out  CTRL_W  registered ALU_Control drive.
- `alu_result`  in  WIDTH  ALU Result (combinational from `alu_*`).
- `alu_zero`  in  1  ALU Zero.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_id`  out  1  requester that owns the response.
- `rsp_result`  out  WIDTH  captured result.
- `rsp_zero`  out  1  captured zero flag.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE → EXEC → RESP → IDLE.
- **IDLE:**
  - Grant is combinational. If only one valid is high, that port wins. If both are high, the port named by priority pointer `prio` wins.
  - `req_readyN` = IDLE & `rst_n` & granted N. At most one ready is high, and never without its valid.
  - On handshake:
    - `alu_a`/`alu_b`/`alu_ctrl` ← winner's a/b/op.
    - `rsp_id`/owner ← N.
    - `prio` ← the other port.
    - state ← EXEC.
- **EXEC:**
  - `alu_*` stable for the full cycle.
  - `rsp_result` ← `alu_result` and `rsp_zero` ← `alu_zero` at the end of the cycle.
  - state ← RESP.
- **RESP:**
  - `rsp_valid`=1. `rsp_id`/`rsp_result`/`rsp_zero` stay stable until `rsp_valid & rsp_ready`.
  - On that handshake, state ← IDLE and `rsp_valid` drops the next cycle.
  - `alu_*` keep their last value; they are not cleared.
- Operands are registered at accept. Requesters may change or drop a/b/op/valid after their handshake.
- Arithmetic, width, and overflow behaviour belong entirely to the ALU. This block neither extends nor truncates.
- Fairness: under continuous requests from both ports, grants strictly alternate 0,1,0,1…
- A lone requester is granted regardless of `prio`. `prio` still flips to the other port.
- **Reset, including mid-operation:**
  - In-flight operation is discarded; no response is produced.
  - state=IDLE, `prio`=0.
  - All outputs 0: `req_ready*`, `alu_a`, `alu_b`, `alu_ctrl`, `rsp_valid`, `rsp_id`, `rsp_result`, `rsp_zero`, `busy`.

## Timing
- Accept at edge N. `alu_*` valid in cycle N+1. `rsp_valid` high from cycle N+2.
- `rsp_valid` stays high until handshaked at edge M. IDLE from M+1; next accept is possible at M+1.
- Minimum issue interval is 3 cycles, when `rsp_ready` is held high.
- `rsp_ready` low stalls in RESP indefinitely. `req_ready*` stay low throughout.
- A valid arriving in EXEC/RESP waits. No request is ever lost or double-accepted.
- `req_ready*` depend combinationally on `req_valid*`, state and `prio` only. There is no path from `rsp_ready`.

## Test plan
- **Single add:**
  - Stimulus: reset; port0 a=10, b=20, op=0; `rsp_ready`=1.
  - Response: ready0 in the first IDLE cycle; `alu_ctrl`=0 next cycle; `rsp_valid`=1, `rsp_id`=0, `rsp_result`=30, `rsp_zero`=0 two cycles after accept.
- **Port1 ops, back-to-back:**
  - Stimulus: sub 10−20, then slt 10,20, then and 6&2.
  - Response: `rsp_result` 0xFFF6, then 1, then 2, in order with `rsp_id`=1; accepts exactly 3 cycles apart.
- **Contention:**
  - Stimulus: both valids held high for 6 ops, port0 adds 1+1 and port1 subs 5−5.
  - Response: grant order 0,1,0,1,0,1. Port1 responses have result 0 with `rsp_zero`=1; port0 responses have result 2 with `rsp_zero`=0.
- **Backpressure:**
  - Stimulus: hold `rsp_ready`=0 for 5 cycles after `rsp_valid` rises, with port1 valid high throughout.
  - Response: `rsp_*` stable, `req_ready1`=0, `busy`=1; port1 is accepted in the cycle after the response handshake.
- **Reset mid-op:**
  - Stimulus: assert `rst_n`=0 in EXEC.
  - Response: next cycle all outputs 0 and `busy`=0; no `rsp_valid` for the aborted op; first grant after release goes to port0 when both request.
- **Operand change after accept:**
  - Stimulus: change `req_a0` the cycle after handshake.
  - Response: result reflects the originally accepted value.
